flu_issue_scheduler: RTL and testbench

- Issue-side scheduler for the execute stage.
- Decides each cycle whether the instruction presented by issue can enter its functional unit (ALU, branch, CSR, mult/div, LSU, FPU).
- Tracks the shared fixed-latency-unit (FLU) writeback port, the single-entry CSR buffer and the variable-latency divider, and drives one-hot FU valid strobes.
- Sits between the issue stage and the execute stage.

---
 rtl/flu_issue_scheduler.sv | 146 ++++++++++++++
 tb/tb_flu_issue_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/flu_issue_scheduler.sv
// Issue-side scheduler: gates entry into each functional unit and arbitrates the shared FLU writeback port.
// Optional issue-stall counter is built when FLU_SCHED_PERF_EN is defined.
module flu_issue_scheduler #(
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned MULT_LAT      = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  input  logic [2:0]               issue_fu_i,
  input  logic [TRANS_ID_BITS-1:0] issue_trans_id_i,
  output logic                     issue_ready_o,
  output logic                     alu_valid_o,
  output logic                     branch_valid_o,
  output logic                     csr_valid_o,
  output logic                     mult_valid_o,
  output logic                     lsu_valid_o,
  output logic                     fpu_valid_o,
  input  logic                     lsu_ready_i,
  input  logic                     fpu_ready_i,
  input  logic                     div_done_i,
  input  logic                     csr_commit_i,
  output logic                     div_busy_o,
  output logic                     csr_pending_o,
  output logic [TRANS_ID_BITS-1:0] div_trans_id_o,
  output logic [31:0]              stall_cnt_o
);

  localparam logic [2:0] FU_NONE   = 3'd0;
  localparam logic [2:0] FU_ALU    = 3'd1;
  localparam logic [2:0] FU_BRANCH = 3'd2;
  localparam logic [2:0] FU_CSR    = 3'd3;
  localparam logic [2:0] FU_MULT   = 3'd4;
  localparam logic [2:0] FU_DIV    = 3'd5;
  localparam logic [2:0] FU_LSU    = 3'd6;
  localparam logic [2:0] FU_FPU    = 3'd7;

  typedef struct packed {
    logic                     valid;
    logic [2:0]               fu;
    logic [TRANS_ID_BITS-1:0] id;
  } issue_req_t;

  typedef enum logic {IDLE, DIV_BUSY} state_e;

  issue_req_t              req;
  state_e                  state_q;
  logic [TRANS_ID_BITS-1:0] div_id_q;
  logic                    csr_pending_q;
  logic [MULT_LAT:1]       occ_q, occ_shift, occ_d;
  logic                    fu_ok;
  logic                    idle;
  logic                    mult_go, div_go, csr_go;

  assign req  = '{valid: issue_valid_i, fu: issue_fu_i, id: issue_trans_id_i};
  assign idle = (state_q == IDLE);

  always_comb begin
    occ_shift = '0;
    for (int k = 1; k < int'(MULT_LAT); k++) occ_shift[k] = occ_q[k+1];
  end

  // A new mult claims the slot just vacated by the shift, so back-to-back mults never collide;
  // only single-cycle units racing an older mult's writeback are refused.
  always_comb begin
    fu_ok = 1'b0;
    case (req.fu)
      FU_NONE:   fu_ok = 1'b1;
      FU_ALU,
      FU_BRANCH: fu_ok = idle & ~occ_q[1];
      FU_CSR:    fu_ok = idle & ~occ_q[1] & ~csr_pending_q;
      FU_MULT:   fu_ok = idle & ~occ_shift[MULT_LAT];
      FU_DIV:    fu_ok = idle & ~(|occ_q);
      FU_LSU:    fu_ok = lsu_ready_i;
      FU_FPU:    fu_ok = fpu_ready_i;
      default:   fu_ok = 1'b0;
    endcase
  end

  assign issue_ready_o  = req.valid & fu_ok & ~flush_i;
  assign alu_valid_o    = issue_ready_o & (req.fu == FU_ALU);
  assign branch_valid_o = issue_ready_o & (req.fu == FU_BRANCH);
  assign csr_valid_o    = issue_ready_o & (req.fu == FU_CSR);
  assign mult_valid_o   = issue_ready_o & ((req.fu == FU_MULT) | (req.fu == FU_DIV));
  assign lsu_valid_o    = issue_ready_o & (req.fu == FU_LSU);
  assign fpu_valid_o    = issue_ready_o & (req.fu == FU_FPU);

  assign mult_go = issue_ready_o & (req.fu == FU_MULT);
  assign div_go  = issue_ready_o & (req.fu == FU_DIV);
  assign csr_go  = csr_valid_o;

  always_comb begin
    occ_d = occ_shift;
    occ_d[MULT_LAT] = occ_shift[MULT_LAT] | mult_go;
    if (flush_i) occ_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  // Divider occupancy; div_done_i only frees the unit from the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_id_q <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (div_go) begin
          state_q  <= DIV_BUSY;
          div_id_q <= req.id;
        end
        DIV_BUSY: if (div_done_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           csr_pending_q <= 1'b0;
    else if (flush_i)      csr_pending_q <= 1'b0;
    else if (csr_go)       csr_pending_q <= 1'b1;
    else if (csr_commit_i) csr_pending_q <= 1'b0;
  end

  assign div_busy_o     = (state_q == DIV_BUSY);
  assign csr_pending_o  = csr_pending_q;
  assign div_trans_id_o = div_id_q;

`ifdef FLU_SCHED_PERF_EN
  logic [31:0] stall_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_q <= '0;
    else if (req.valid & ~issue_ready_o & ~flush_i & ~(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end
  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_flu_issue_scheduler.sv
// Directed bench for flu_issue_scheduler (MULT_LAT=1) with hand-computed expectations.
module tb_flu_issue_scheduler;
  localparam logic [2:0] NONE = 3'd0, ALU = 3'd1, BRANCH = 3'd2, CSR = 3'd3,
                         MULT = 3'd4, DIV = 3'd5, LSU = 3'd6, FPU = 3'd7;

  logic clk_i = 1'b0, rst_ni, flush_i, issue_valid_i;
  logic [2:0] issue_fu_i, issue_trans_id_i, div_trans_id_o;
  logic issue_ready_o, alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o,
        lsu_valid_o, fpu_valid_o, lsu_ready_i, fpu_ready_i, div_done_i,
        csr_commit_i, div_busy_o, csr_pending_o;
  logic [31:0] stall_cnt_o;
  logic [5:0] strb;
  int total = 0, bad = 0;

  always #5 clk_i = ~clk_i;
  assign strb = {alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o, lsu_valid_o, fpu_valid_o};

  flu_issue_scheduler #(.TRANS_ID_BITS(3), .MULT_LAT(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .issue_valid_i(issue_valid_i),
    .issue_fu_i(issue_fu_i), .issue_trans_id_i(issue_trans_id_i), .issue_ready_o(issue_ready_o),
    .alu_valid_o(alu_valid_o), .branch_valid_o(branch_valid_o), .csr_valid_o(csr_valid_o),
    .mult_valid_o(mult_valid_o), .lsu_valid_o(lsu_valid_o), .fpu_valid_o(fpu_valid_o),
    .lsu_ready_i(lsu_ready_i), .fpu_ready_i(fpu_ready_i), .div_done_i(div_done_i),
    .csr_commit_i(csr_commit_i), .div_busy_o(div_busy_o), .csr_pending_o(csr_pending_o),
    .div_trans_id_o(div_trans_id_o), .stall_cnt_o(stall_cnt_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk_i); #1;
  endtask

  task automatic present(input logic [2:0] fu, input logic [2:0] id);
    issue_valid_i = 1'b1; issue_fu_i = fu; issue_trans_id_i = id;
  endtask

  initial begin
    rst_ni = 0; flush_i = 0; issue_valid_i = 0; issue_fu_i = NONE; issue_trans_id_i = 0;
    lsu_ready_i = 0; fpu_ready_i = 0; div_done_i = 0; csr_commit_i = 0;
    #12;
    chk("rst_ready", issue_ready_o, 0);
    chk("rst_strb", strb, 0);
    chk("rst_busy", div_busy_o, 0);
    chk("rst_pend", csr_pending_o, 0);
    chk("rst_id", div_trans_id_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    rst_ni = 1;
    go();

    present(ALU, 3'd2); #1;
    chk("alu_ready", issue_ready_o, 1);
    chk("alu_strb", strb, 6'b100000);

    go(); present(MULT, 3'd0); #1;
    chk("mult_ready", issue_ready_o, 1);
    chk("mult_strb", strb, 6'b000100);
    go(); present(ALU, 3'd1); #1;
    chk("alu_after_mult_ready", issue_ready_o, 0);
    chk("alu_after_mult_strb", strb, 0);
    go(); #1;
    chk("alu_t2_ready", issue_ready_o, 1);
    chk("alu_t2_strb", strb, 6'b100000);

    go(); present(MULT, 3'd0); #1;
    chk("mult_a_ready", issue_ready_o, 1);
    go(); #1;
    chk("mult_b2b_ready", issue_ready_o, 1);
    go(); present(DIV, 3'd5); #1;
    chk("div_occ_ready", issue_ready_o, 0);
    go(); #1;
    chk("div_ready", issue_ready_o, 1);
    chk("div_strb", strb, 6'b000100);
    go(); #1;
    chk("div_busy", div_busy_o, 1);
    chk("div_id", div_trans_id_o, 5);
    present(ALU, 3'd1);
    for (int i = 1; i <= 9; i++) begin
      #1; chk("alu_in_div", issue_ready_o, 0);
      go();
    end
    div_done_i = 1; #1;
    chk("alu_div_done_cycle", issue_ready_o, 0);
    go(); div_done_i = 0; #1;
    chk("div_idle", div_busy_o, 0);
    chk("alu_after_div", issue_ready_o, 1);

    go(); present(CSR, 3'd3); #1;
    chk("csr_ready", issue_ready_o, 1);
    chk("csr_strb", strb, 6'b001000);
    go(); #1;
    chk("csr_pend", csr_pending_o, 1);
    chk("csr2_ready", issue_ready_o, 0);
    go(); csr_commit_i = 1; #1;
    chk("csr_commit_same", issue_ready_o, 0);
    go(); csr_commit_i = 0; #1;
    chk("csr_pend_clr", csr_pending_o, 0);
    chk("csr_retry_ready", issue_ready_o, 1);

    go(); #1;
    chk("csr_pend2", csr_pending_o, 1);
    present(DIV, 3'd6); #1;
    chk("div6_ready", issue_ready_o, 1);
    go(); #1;
    chk("div6_busy", div_busy_o, 1);
    chk("div6_id", div_trans_id_o, 6);
    chk("div6_pend", csr_pending_o, 1);
    present(ALU, 3'd1); flush_i = 1; #1;
    chk("flush_ready", issue_ready_o, 0);
    chk("flush_strb", strb, 0);
    go(); flush_i = 0; #1;
    chk("flush_busy", div_busy_o, 0);
    chk("flush_pend", csr_pending_o, 0);
    chk("post_flush_alu", issue_ready_o, 1);

    go(); issue_valid_i = 0; rst_ni = 0; #2; rst_ni = 1;
    present(LSU, 3'd4); lsu_ready_i = 0;
    for (int i = 0; i < 7; i++) begin
      #1; chk("lsu_stall", issue_ready_o, 0);
      go();
    end
    flush_i = 1; #1;
    chk("lsu_flush_ready", issue_ready_o, 0);
    go(); flush_i = 0; #1;
`ifdef FLU_SCHED_PERF_EN
    chk("stall_cnt", stall_cnt_o, 7);
`else
    chk("stall_cnt", stall_cnt_o, 0);
`endif
    lsu_ready_i = 1; #1;
    chk("lsu_ready", issue_ready_o, 1);
    chk("lsu_strb", strb, 6'b000010);

    go(); present(FPU, 3'd0); fpu_ready_i = 0; #1;
    chk("fpu_stall", issue_ready_o, 0);
    fpu_ready_i = 1; #1;
    chk("fpu_ready", issue_ready_o, 1);
    chk("fpu_strb", strb, 6'b000001);
    present(NONE, 3'd0); #1;
    chk("none_ready", issue_ready_o, 1);
    chk("none_strb", strb, 0);
    present(BRANCH, 3'd1); #1;
    chk("br_ready", issue_ready_o, 1);
    chk("br_strb", strb, 6'b010000);
    issue_valid_i = 0; issue_fu_i = ALU; #1;
    chk("novalid_ready", issue_ready_o, 0);
    chk("novalid_strb", strb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
